// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: hazard sources and debug requests in, per-stage
// enable/flush controls, halt status and perf counters out.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic             load_stall_i;
  logic             branching_i;
  logic             imem_ready_i;
  logic             dmem_busy_i;
  logic             halt_req_i;
  logic             resume_req_i;
  logic             pc_write_en_o;
  logic             if_id_write_en_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             ex_mem_write_en_o;
  logic             halted_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] flush_events_o;

  // Core side: raises hazards and debug requests, consumes controls
  modport master (
    output load_stall_i, branching_i, imem_ready_i, dmem_busy_i,
           halt_req_i, resume_req_i,
    input  pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_flush_o,
           ex_mem_write_en_o, halted_o, stall_cycles_o, flush_events_o
  );

  // Controller side
  modport slave (
    input  load_stall_i, branching_i, imem_ready_i, dmem_busy_i,
           halt_req_i, resume_req_i,
    output pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_flush_o,
           ex_mem_write_en_o, halted_o, stall_cycles_o, flush_events_o
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core with debug halt/drain/resume FSM.
// Define PIPE_PERF_CNT_EN to build the stall-cycle and flush-event counters.
module pipeline_hazard_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic                         clk_i,
  input logic                         rst_i,
  pipeline_hazard_controller_if.slave hz
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] drain_cnt_reg, drain_cnt_next;
  logic          halted_reg;

  logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we;

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    pc_we          = 1'b0;
    if_id_we       = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_we      = 1'b0;

    case (state_reg)
      RUN: begin
        if (hz.dmem_busy_i) begin
          // Whole pipe frozen; every other source waits for the next cycle
        end else if (hz.branching_i) begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_we   = 1'b1;
        end else if (hz.load_stall_i) begin
          ex_mem_we = 1'b1;
        end else if (!hz.imem_ready_i) begin
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          ex_mem_we   = 1'b1;
        end else begin
          pc_we     = 1'b1;
          if_id_we  = 1'b1;
          ex_mem_we = 1'b1;
        end

        if (hz.halt_req_i && !hz.dmem_busy_i) begin
          if (DRAIN_CYCLES == 0) begin
            state_next = HALTED;
          end else begin
            state_next     = DRAIN;
            drain_cnt_next = DW'(DRAIN_CYCLES);
          end
        end
      end

      DRAIN: begin
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
        ex_mem_we   = !hz.dmem_busy_i;
        // Latch the branch target but fetch nothing further
        if (hz.branching_i) begin
          pc_we       = 1'b1;
          id_ex_flush = 1'b1;
        end
        if (!hz.dmem_busy_i) begin
          if (drain_cnt_reg <= DW'(1)) begin
            drain_cnt_next = '0;
            state_next     = HALTED;
          end else begin
            drain_cnt_next = drain_cnt_reg - DW'(1);
          end
        end
      end

      HALTED: begin
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
        ex_mem_we   = 1'b1;
        if (hz.resume_req_i) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next     = RUN;
        drain_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      halted_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      halted_reg    <= (state_next == HALTED);
    end
  end

  // Reset must silence the pipe immediately, not at the next edge
  assign hz.pc_write_en_o     = pc_we       & ~rst_i;
  assign hz.if_id_write_en_o  = if_id_we    & ~rst_i;
  assign hz.if_id_flush_o     = if_id_flush & ~rst_i;
  assign hz.id_ex_flush_o     = id_ex_flush & ~rst_i;
  assign hz.ex_mem_write_en_o = ex_mem_we   & ~rst_i;
  assign hz.halted_o          = halted_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (state_reg == RUN && !pc_we) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (id_ex_flush && (state_reg == RUN || state_reg == DRAIN)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cycles_o = stall_cnt_reg;
  assign hz.flush_events_o = flush_cnt_reg;
`else
  assign hz.stall_cycles_o = '0;
  assign hz.flush_events_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: priority resolution, halt/drain/
// resume timing, asynchronous reset and (when built in) the performance counters.
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 32;

`ifdef PIPE_PERF_CNT_EN
  localparam int EXP_STALLS  = 4;
  localparam int EXP_FLUSHES = 2;
`else
  localparam int EXP_STALLS  = 0;
  localparam int EXP_FLUSHES = 0;
`endif

  // Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we}
  localparam logic [4:0] C_RUN    = 5'b11001;
  localparam logic [4:0] C_BRANCH = 5'b11111;
  localparam logic [4:0] C_LSTALL = 5'b00001;
  localparam logic [4:0] C_IWAIT  = 5'b01101;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_DRAIN  = 5'b01101;
  localparam logic [4:0] C_DRBUSY = 5'b01100;
  localparam logic [4:0] C_HALTED = 5'b01101;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz_if ();

  pipeline_hazard_controller #(
    .DRAIN_CYCLES (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ctrl();
    return {hz_if.pc_write_en_o, hz_if.if_id_write_en_o, hz_if.if_id_flush_o,
            hz_if.id_ex_flush_o, hz_if.ex_mem_write_en_o};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end else begin
      $display("ok   %s: %0h", tag, actual);
    end
  endtask

  // One cycle: inputs change at the falling edge, outputs sampled 1 ns later
  task automatic cyc(input logic ls, input logic br, input logic imr,
                     input logic busy, input logic halt, input logic res);
    @(negedge clk);
    hz_if.load_stall_i = ls;
    hz_if.branching_i  = br;
    hz_if.imem_ready_i = imr;
    hz_if.dmem_busy_i  = busy;
    hz_if.halt_req_i   = halt;
    hz_if.resume_req_i = res;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    hz_if.load_stall_i = 1'b0;
    hz_if.branching_i  = 1'b0;
    hz_if.imem_ready_i = 1'b1;
    hz_if.dmem_busy_i  = 1'b0;
    hz_if.halt_req_i   = 1'b0;
    hz_if.resume_req_i = 1'b0;
    #2;
    check_eq("reset_ctrl", 32'(ctrl()), 32'(C_FREEZE));
    check_eq("reset_halted", 32'(hz_if.halted_o), 32'd0);
    check_eq("reset_stall_cnt", hz_if.stall_cycles_o, 32'd0);
    check_eq("reset_flush_cnt", hz_if.flush_events_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      check_eq($sformatf("run_idle_%0d", i), 32'(ctrl()), 32'(C_RUN));
    end
    check_eq("run_halted", 32'(hz_if.halted_o), 32'd0);

    cyc(1, 1, 1, 0, 0, 0); check_eq("branch_over_lstall", 32'(ctrl()), 32'(C_BRANCH));
    cyc(1, 0, 1, 0, 0, 0); check_eq("lstall_alone", 32'(ctrl()), 32'(C_LSTALL));
    cyc(0, 0, 0, 0, 0, 0); check_eq("imem_wait", 32'(ctrl()), 32'(C_IWAIT));
    cyc(0, 1, 1, 1, 0, 0); check_eq("busy_over_branch", 32'(ctrl()), 32'(C_FREEZE));
    cyc(0, 1, 1, 0, 0, 0); check_eq("branch_after_busy", 32'(ctrl()), 32'(C_BRANCH));

    // Halt scenario, cycles numbered as in the drain timeline
    cyc(0, 0, 1, 0, 0, 0);                                        // 1..3 idle
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0); check_eq("c4_halt_deferred", 32'(ctrl()), 32'(C_FREEZE));
    cyc(0, 0, 1, 0, 1, 0); check_eq("c5_halt_accept", 32'(ctrl()), 32'(C_RUN));
    cyc(0, 0, 1, 0, 1, 0); check_eq("c6_drain", 32'(ctrl()), 32'(C_DRAIN));
    cyc(0, 0, 1, 1, 1, 0); check_eq("c7_drain_busy", 32'(ctrl()), 32'(C_DRBUSY));
    cyc(0, 0, 1, 0, 0, 1); check_eq("c8_drain_resume_ign", 32'(ctrl()), 32'(C_DRAIN));
    cyc(0, 1, 1, 0, 0, 0); check_eq("c9_drain_branch", 32'(ctrl()), 32'(C_BRANCH));
    check_eq("c9_not_halted", 32'(hz_if.halted_o), 32'd0);
    cyc(0, 0, 1, 0, 0, 0); check_eq("c10_halted", 32'(hz_if.halted_o), 32'd1);
    check_eq("c10_halted_ctrl", 32'(ctrl()), 32'(C_HALTED));
    cyc(0, 0, 1, 0, 0, 0); check_eq("c11_halted", 32'(hz_if.halted_o), 32'd1);
    cyc(0, 0, 1, 0, 0, 1); check_eq("c12_resume_ctrl", 32'(ctrl()), 32'(C_HALTED));
    cyc(0, 0, 1, 0, 0, 0); check_eq("c13_run_ctrl", 32'(ctrl()), 32'(C_RUN));
    check_eq("c13_halted_low", 32'(hz_if.halted_o), 32'd0);

    // Asynchronous reset while draining
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0); check_eq("pre_rst_drain", 32'(ctrl()), 32'(C_DRAIN));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_in_drain_ctrl", 32'(ctrl()), 32'(C_FREEZE));
    check_eq("rst_in_drain_halted", 32'(hz_if.halted_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 1, 0, 0, 0); check_eq("post_rst_run", 32'(ctrl()), 32'(C_RUN));

    // Counter scenario from a clean reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check_eq("stall_cycles", hz_if.stall_cycles_o, 32'(EXP_STALLS));
    check_eq("flush_events", hz_if.flush_events_o, 32'(EXP_FLUSHES));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage core. Merges hazard sources (ID load-use stall, EX branch resolution, instruction-memory wait, data-memory busy) with a debug halt/drain/resume FSM, producing per-stage write-enable and flush controls. Drives PC, IF/ID and EX/MEM registers and the ID stage's branching_id_i flush input.

Parameters:
DRAIN_CYCLES, 3, cycles needed to empty ID/EX, EX/MEM and MEM/WB after fetch stops before HALTED
CNT_W, 32, width of optional performance counters

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
load_stall_i  input  1  load-use stall from ID hazard detection
branching_i  input  1  taken branch/jump resolved in EX this cycle
imem_ready_i  input  1  fetched instruction valid this cycle
dmem_busy_i  input  1  data memory not ready; whole pipe must freeze
halt_req_i  input  1  debug halt request, level
resume_req_i  input  1  debug resume request, single-cycle pulse
pc_write_en_o  output  1  PC register update enable
if_id_write_en_o  output  1  IF/ID register update enable
if_id_flush_o  output  1  load NOP into IF/ID
id_ex_flush_o  output  1  to ID branching_id_i; converts ID/EX entry to NOP
ex_mem_write_en_o  output  1  EX/MEM and MEM/WB update enable
halted_o  output  1  core halted, pipeline empty (registered)
stall_cycles_o  output  CNT_W  optional, see below
flush_events_o  output  CNT_W  optional, see below

Behaviour:
- Reset (async, rst_i=1): state=RUN, drain counter=0, halted_o=0, counters=0. While rst_i high all outputs forced: pc_write_en_o=0, if_id_write_en_o=0, ex_mem_write_en_o=0, flushes=0.
- Control outputs are combinational from state and current inputs (zero latency); only state, counter, halted_o registered.
- States: RUN, DRAIN, HALTED (2-bit encoding).
- RUN, fixed priority, highest first:
  1. dmem_busy_i: freeze all; pc_we=0, if_id_we=0, ex_mem_we=0, no flushes; other sources ignored this cycle.
  2. branching_i: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=1, ex_mem_we=1. Overrides load_stall_i (stalled instruction is on wrong path).
  3. load_stall_i: pc_we=0, if_id_we=0, no flushes (ID inserts its own bubble), ex_mem_we=1.
  4. !imem_ready_i: pc_we=0, if_id_we=1, if_id_flush=1 (bubble into ID).
  5. else all enables 1, flushes 0.
- RUN -> DRAIN when halt_req_i=1 and dmem_busy_i=0; drain counter loaded with DRAIN_CYCLES. halt_req_i with dmem_busy_i=1 deferred until busy drops.
- DRAIN: pc_we=0, if_id_we=1, if_id_flush=1 each cycle; ex_mem_we=!dmem_busy_i. Counter decrements only when dmem_busy_i=0. branching_i in DRAIN: pc_we=1, id_ex_flush=1 (target captured, no further fetch); counter unaffected. halt_req_i deassert in DRAIN ignored. Counter reaching 0 -> HALTED.
- HALTED: halted_o=1 (asserted first cycle in HALTED); pc_we=0, if_id_we=1, if_id_flush=1, ex_mem_we=1 (pipe empty, harmless). resume_req_i=1 -> RUN next cycle, halted_o=0 same edge. resume_req_i outside HALTED ignored. If halt_req_i still high after resume, RUN re-enters DRAIN on following cycle (one instruction fetched).
- Counter never underflows; DRAIN_CYCLES=0 goes RUN -> HALTED directly.
- Reset mid-DRAIN/HALTED: immediate return to RUN, counter cleared.

Optional Feature:
Macro PIPE_PERF_CNT_EN. Defined: stall_cycles_o increments every RUN cycle with pc_we=0; flush_events_o increments every cycle id_ex_flush_o=1 in RUN/DRAIN; both wrap at 2^CNT_W, clear on reset. Undefined: ports present, tied to 0, no counter flops.

Test Plan:
- Reset then imem_ready_i=1, no hazards 10 cycles -> all enables 1, flushes 0, halted_o=0.
- load_stall_i=1 and branching_i=1 same cycle -> pc_we=1, if_id_flush=1, id_ex_flush=1; next cycle load_stall_i alone -> pc_we=0, if_id_we=0.
- dmem_busy_i=1 with branching_i=1 -> all enables 0, no flush; drop busy next cycle with branching_i=1 -> flushes asserted.
- halt_req_i at cycle 5, DRAIN_CYCLES=3, dmem_busy_i=1 at cycle 7 -> halted_o rises at cycle 10; resume pulse cycle 12 -> RUN, pc_we=1 at cycle 13.
- Assert rst_i during DRAIN -> outputs forced instantly, halted_o=0, RUN after release.
- With PIPE_PERF_CNT_EN: 4 load stalls + 2 branches -> stall_cycles_o=4, flush_events_o=2.
